// File: rtl/ecc_60_wr_pipe.sv
// ecc_60_wr_pipe: write-side SECDED encoder for the 60-bit ECC FIFO path.
// Data is encoded into a 68-bit codeword {parity[7:0], data[59:0]} on the way
// into a 2-entry skid buffer. A one-shot injection request can flip one or two
// codeword bits of the next accepted word so the read-side checker can be
// exercised in system.
module ecc_60_wr_pipe #(
  parameter int DATA_WIDTH   = 60,
  parameter int PARITY_WIDTH = 8,
  parameter int CW_WIDTH     = 68,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW_WIDTH-1:0]   out_cw,
  input  logic                  inj_arm,
  input  logic [1:0]            inj_mode,
  input  logic [6:0]            inj_pos_a,
  input  logic [6:0]            inj_pos_b,
  output logic                  inj_armed,
  output logic                  inj_done,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  // Hamming position of data bit idx: the idx-th integer >= 3 that is not a
  // power of two. Evaluated only at elaboration to build the check columns.
  function automatic logic [6:0] data_pos(input int idx);
    int         n;
    logic [6:0] r;
    n = 0;
    r = '0;
    for (int c = 3; c < 128; c++) begin
      if ((c & (c - 1)) != 0) begin
        if (n == idx) r = 7'(c);
        n++;
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // Check-matrix column per data bit: low 7 bits are the position, bit 7 is
  // set for even-popcount positions so every column has odd weight.
  logic [PARITY_WIDTH-1:0] enc_col [DATA_WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_col
      localparam logic [6:0] POS = data_pos(gi);
      assign enc_col[gi] = {~(^POS), POS};
    end
  endgenerate

  state_t                  state_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [CW_WIDTH-1:0]     head_q;
  logic [CW_WIDTH-1:0]     tail_q;

  logic                    inj_armed_q;
  logic                    inj_done_q;
  logic [1:0]              inj_mode_q;
  logic [6:0]              inj_pos_a_q;
  logic [6:0]              inj_pos_b_q;

  logic [CNT_WIDTH-1:0]    word_cnt_q;

  logic                    accept;
  logic                    drain;
  logic                    inj_apply;
  logic [PARITY_WIDTH-1:0] parity;
  logic [CW_WIDTH-1:0]     flip_mask;
  logic [CW_WIDTH-1:0]     enc_cw;

  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid_q && out_ready;
  // A request armed in an earlier cycle is consumed by the next accepted word.
  assign inj_apply = accept && inj_armed_q;

  // Parity generation: XOR together the columns of every set data bit.
  always_comb begin
    parity = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (in_data[i]) parity = parity ^ enc_col[i];
    end
  end

  // Flip mask from the pending request; out-of-range positions flip nothing
  // and an equal pair in double mode collapses to a single flip.
  always_comb begin
    flip_mask = '0;
    if (inj_pos_a_q < 7'(CW_WIDTH)) flip_mask[inj_pos_a_q] = 1'b1;
    if ((inj_mode_q == 2'b10) && (inj_pos_b_q < 7'(CW_WIDTH)))
      flip_mask[inj_pos_b_q] = 1'b1;
  end

  // Codeword entering the buffer, with any injection already folded in.
  always_comb begin
    enc_cw = {parity, in_data};
    if (inj_apply) enc_cw = enc_cw ^ flip_mask;
  end

  // Skid-buffer FSM: head_q is presented downstream, tail_q holds the second
  // word while the output is stalled; handshake outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            head_q      <= enc_cw;
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
          end
        end
        S_ONE: begin
          case ({accept, drain})
            2'b10: begin
              tail_q     <= enc_cw;
              state_q    <= S_TWO;
              in_ready_q <= 1'b0;
            end
            2'b01: begin
              state_q     <= S_EMPTY;
              out_valid_q <= 1'b0;
            end
            2'b11: begin
              head_q <= enc_cw;
            end
            default: begin
            end
          endcase
        end
        S_TWO: begin
          if (drain) begin
            head_q     <= tail_q;
            state_q    <= S_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Injection request capture, consumption and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_armed_q <= 1'b0;
      inj_done_q  <= 1'b0;
      inj_mode_q  <= 2'b00;
      inj_pos_a_q <= '0;
      inj_pos_b_q <= '0;
    end else begin
      inj_done_q <= inj_apply;
      if (inj_arm) begin
        inj_mode_q  <= inj_mode;
        inj_pos_a_q <= inj_pos_a;
        inj_pos_b_q <= inj_pos_b;
        inj_armed_q <= (inj_mode == 2'b01) || (inj_mode == 2'b10);
      end else if (inj_apply) begin
        inj_armed_q <= 1'b0;
      end
    end
  end

  // Saturating count of accepted input words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
    end else if (accept && (word_cnt_q != {CNT_WIDTH{1'b1}})) begin
      word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_cw    = head_q;
  assign inj_armed = inj_armed_q;
  assign inj_done  = inj_done_q;
  assign word_cnt  = word_cnt_q;

endmodule
